ifetch_s: RTL and testbench
===========================

// Module: ifetch_s
// PURPOSE
// - Instruction-fetch stage: owns the PC, issues one instruction-memory request at a time, and presents {is_valid_out, pc_out, instr_out} to the IF/ID register.
// - Honours hazard-unit stall (hold outputs) and branch/jump flush (redirect PC, squash in-flight fetch).
// - Sits between instruction memory and ifid_s; its outputs drive ifid_s is_valid_in/pc_in/instr_in directly.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC fetched first after reset
// - PC_STEP   4              sequential PC increment (bytes)
// PORTS
// - clk           in   1   clock, all state on posedge
// - reset         in   1   asynchronous, active-high reset
// - is_stall      in   1   hazard unit: hold output registers this cycle
// - is_flush      in   1   redirect: discard fetch state, restart at redirect_pc
// - redirect_pc   in   32  branch/jump target, sampled when is_flush=1
// - imem_req      out  1   fetch request valid, held until imem_gnt
// - imem_addr     out  32  fetch address, stable while imem_req=1 and no flush
// - imem_gnt      in   1   memory accepts request this cycle
// - imem_rvalid   in   1   read data valid; earliest one cycle after gnt
// - imem_rdata    in   32  instruction word
// - is_valid_out  out  1   output slot holds a real instruction
// - pc_out        out  32  PC of instr_out
// - instr_out     out  32  fetched instruction
// BEHAVIOUR
// - Reset (async): state=S_IDLE, pc=RESET_PC, skid empty, drop=0; is_valid_out=0, pc_out=0, instr_out=0, imem_req=0, imem_addr=RESET_PC.
// - FSM: S_IDLE -> S_REQ unconditionally on first clock after reset deasserts.
// - S_REQ: imem_req=1, imem_addr=pc. gnt -> S_WAIT, req_pc<=pc, pc<=pc+PC_STEP (32-bit wrap, 0xFFFF_FFFC+4=0).
// - S_REQ: request issued only when skid buffer empty; else imem_req=0, stay.
// - S_WAIT: imem_req=0; rvalid -> S_REQ, response {req_pc, imem_rdata} delivered.
// - S_DRAIN: imem_req=0; rvalid discarded -> S_REQ.
// - At most one outstanding request; throughput 1 instr / 2 cycles with single-cycle memory.
// - Output register: when !is_stall it loads, in priority order, skid entry, live delivered response, else bubble (is_valid_out<=0).
// - When is_stall: output register holds; a response delivered that cycle goes to 1-entry skid buffer.
// - Latency: gnt cycle N, rvalid N+1, is_valid_out=1 at N+2 (no stall).
// - Flush (priority over stall, and over gnt/rvalid handling):
//   - pc<=redirect_pc; skid cleared; is_valid_out<=0.
//   - state -> S_DRAIN if in S_WAIT without rvalid, or S_REQ with gnt same cycle; else -> S_REQ.
//   - flush in S_DRAIN: pc updated, stay in S_DRAIN.
//   - flush in S_REQ without gnt: request withdrawn, retargeted to redirect_pc next cycle.
// - rvalid in S_IDLE/S_REQ is a protocol error: ignored.
// - Reset mid-fetch: in-flight response forgotten; memory shares reset and drops it.
// CONFIGURATION
// - IFETCH_ALIGN_CHECK_EN defined: adds port misalign_out (out, 1).
//   - Flush with redirect_pc[1:0]!=0: pc<={redirect_pc[31:2],2'b00}; misalign_out=1 for the next cycle only; reset 0.
// - IFETCH_ALIGN_CHECK_EN undefined: no misalign_out port; redirect_pc[1:0] ignored, pc[1:0] always 2'b00.
// TESTING
// - Reset release, 1-cycle memory returning addr^32'hA5A5_0000 -> req addr 0,4,8; is_valid_out pulses with pc_out 0,4,8, instr_out matching.
// - is_stall high 3 cycles while response for pc 0x8 arrives -> outputs frozen, skid holds; on release pc_out=0x8 next cycle, no request issued while skid full.
// - is_flush, redirect_pc=0x100, during S_WAIT for pc 0xC -> 0xC response dropped, next imem_addr=0x100, next valid pc_out=0x100.
// - is_flush and imem_gnt same cycle -> S_DRAIN; granted response discarded; next fetch 0x100.
// - Flush and stall same cycle -> is_valid_out=0, redirect taken.
// - PC=0xFFFF_FFFC fetch -> next addr 0x0000_0000; assert reset mid-S_WAIT -> all outputs 0, restart at RESET_PC.

Source files
------------

// File: rtl/ifetch_s.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, and feeds the IF/ID register through a 1-entry skid.
// Optional build macro IFETCH_ALIGN_CHECK_EN adds misalign_out for flushes to non-word-aligned targets.
module ifetch_s #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic        is_flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        is_valid_out,
  output logic [31:0] pc_out,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic [31:0] instr_out,
  output logic        misalign_out
`else
  output logic [31:0] instr_out
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // S_DRAIN: a granted response is still owed by memory but must be thrown away
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, req_pc, skid_pc, skid_instr;
  logic        skid_valid;
  logic        accept, deliver;
  logic [31:0] redirect_word;

  assign redirect_word = {redirect_pc[31:2], 2'b00};
  assign accept        = imem_req && imem_gnt;
  assign deliver       = (state == S_WAIT) && imem_rvalid && !is_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ: begin
        if (is_flush)    state_nxt = accept ? S_DRAIN : S_REQ;
        else if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (is_flush)         state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem_rvalid) state_nxt = S_REQ;
      end
      S_DRAIN: begin
        if (!is_flush && imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state == S_REQ) && !skid_valid;
    imem_addr = pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      skid_valid   <= 1'b0;
      skid_pc      <= 32'h0;
      skid_instr   <= 32'h0;
      is_valid_out <= 1'b0;
      pc_out       <= 32'h0;
      instr_out    <= 32'h0;
    end else begin
      if (is_flush) begin
        pc <= redirect_word;
      end else if (accept) begin
        req_pc <= pc;
        pc     <= pc + STEP;
      end

      if (is_flush) begin
        skid_valid   <= 1'b0;
        is_valid_out <= 1'b0;
      end else if (!is_stall) begin
        if (skid_valid) begin
          is_valid_out <= 1'b1;
          pc_out       <= skid_pc;
          instr_out    <= skid_instr;
          skid_valid   <= 1'b0;
        end else if (deliver) begin
          is_valid_out <= 1'b1;
          pc_out       <= req_pc;
          instr_out    <= imem_rdata;
        end else begin
          is_valid_out <= 1'b0;
        end
      end else if (deliver) begin
        // held output cannot take the response, park it until the stall lifts
        skid_valid <= 1'b1;
        skid_pc    <= req_pc;
        skid_instr <= imem_rdata;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_out <= 1'b0;
    else       misalign_out <= is_flush && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_ifetch_s.sv
// Scoreboard bench for ifetch_s: a variable-latency memory model pushes expected {pc, instr} on each response,
// the output monitor pops and compares whenever a new instruction is presented.
module tb_ifetch_s;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, is_stall, is_flush, gnt_en;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        is_valid_out;
  logic [31:0] pc_out, instr_out;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;
  int mem_lat  = 1;

  logic [63:0] sb_q[$];
  bit          adv = 1'b0;

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en;

  ifetch_s dut (
    .clk         (clk),
    .reset       (reset),
    .is_stall    (is_stall),
    .is_flush    (is_flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .is_valid_out(is_valid_out),
    .pc_out      (pc_out),
`ifdef IFETCH_ALIGN_CHECK_EN
    .instr_out   (instr_out),
    .misalign_out(misalign_out)
`else
    .instr_out   (instr_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] t, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (imem_req && imem_addr == t) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // memory model: grants whenever gnt_en, answers mem_lat cycles later with addr^K
  initial begin
    bit          pend = 1'b0, pdrop = 1'b0, rdrop = 1'b0, nxt_rv;
    int          cnt = 0;
    logic [31:0] paddr = '0, raddr = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        pend = 1'b0;
        adv  = 1'b0;
        sb_q.delete();
        imem_rvalid <= 1'b0;
        imem_rdata  <= '0;
      end else begin
        adv = !is_stall;
        if (is_flush) sb_q.delete();
        if (imem_rvalid && !rdrop && !is_flush) sb_q.push_back({raddr, raddr ^ K});
        nxt_rv = 1'b0;
        if (pend) begin
          pdrop = pdrop | is_flush;
          cnt--;
          if (cnt == 0) begin
            nxt_rv = 1'b1;
            pend   = 1'b0;
          end
        end
        if (imem_req && imem_gnt) begin
          pend  = 1'b1;
          cnt   = mem_lat - 1;
          paddr = imem_addr;
          pdrop = is_flush;
          if (cnt == 0) begin
            nxt_rv = 1'b1;
            pend   = 1'b0;
          end
        end
        if (nxt_rv) begin
          raddr = paddr;
          rdrop = pdrop;
        end
        imem_rvalid <= nxt_rv;
        imem_rdata  <= nxt_rv ? (paddr ^ K) : 32'h0;
      end
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && is_valid_out && adv) begin
        n_pop++;
        check("sb_avail", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("out_pc", pc_out, e[63:32]);
          check("out_instr", instr_out, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; is_stall = 1'b0; is_flush = 1'b0; redirect_pc = '0; gnt_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(is_valid_out), 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("c2_req", 32'(imem_req), 32'd0);
    check("c2_valid", 32'(is_valid_out), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(is_valid_out), 32'd1);
    check("c3_addr", imem_addr, 32'h4);
    repeat (2) @(negedge clk);
    check("c5_addr", imem_addr, 32'h8);
    @(negedge clk);
    is_stall = 1'b1;
    @(negedge clk);
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(is_valid_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("stall_hold_req", 32'(imem_req), 32'd0);
    check("stall_hold_valid", 32'(is_valid_out), 32'd0);
    is_stall = 1'b0;
    @(negedge clk);
    check("rel_valid", 32'(is_valid_out), 32'd1);
    check("rel_pc", pc_out, 32'h8);
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", imem_addr, 32'hC);
    mem_lat = 2;
    @(negedge clk);
    check("wait_req", 32'(imem_req), 32'd0);
    is_flush = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    is_flush = 1'b0; mem_lat = 1;
    check("drain_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    repeat (2) @(negedge clk);
    check("redir_valid", 32'(is_valid_out), 32'd1);
    check("fg_req", 32'(imem_req), 32'd1);
    is_flush = 1'b1;
    @(negedge clk);
    is_flush = 1'b0;
    check("fg_drain_req", 32'(imem_req), 32'd0);
    check("fg_valid", 32'(is_valid_out), 32'd0);
    @(negedge clk);
    check("fg_addr", imem_addr, 32'h100);
    repeat (2) @(negedge clk);
    check("fs_pre_valid", 32'(is_valid_out), 32'd1);
    is_stall = 1'b1; is_flush = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("fs_valid", 32'(is_valid_out), 32'd0);
    is_stall = 1'b0; is_flush = 1'b0;
    wait_addr("fs_addr", 32'h40, 10);
    is_flush = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    is_flush = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    check("misalign_set", 32'(misalign_out), 32'd1);
`endif
    @(negedge clk);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("misalign_clr", 32'(misalign_out), 32'd0);
`endif
    check("align_addr", imem_addr, 32'h100);
    repeat (4) @(negedge clk);
    is_flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    is_flush = 1'b0;
    wait_addr("wrap_top", 32'hFFFF_FFFC, 6);
    wait_addr("wrap_zero", 32'h0, 6);
    repeat (4) @(negedge clk);
    mem_lat = 3;
    is_flush = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    is_flush = 1'b0;
    wait_addr("pre_rst_addr", 32'h300, 6);
    @(negedge clk);
    check("mid_wait_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    #1;
    check("mrst_valid", 32'(is_valid_out), 32'd0);
    check("mrst_pc", pc_out, 32'h0);
    check("mrst_instr", instr_out, 32'h0);
    check("mrst_req", 32'(imem_req), 32'd0);
    check("mrst_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    mem_lat = 1;
    reset = 1'b0;
    wait_addr("restart_addr", 32'h0, 6);
    repeat (4) @(negedge clk);
    gnt_en = 1'b0;
    repeat (6) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("sb_pops", 32'(n_pop >= 8), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
